// File: rtl/fetch_queue_if.sv
// Fetch/decode side bundle of the instruction fetch queue.
// master drives fetch pairs, flush and deq; slave is the queue itself.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic [1:0]       in_count;
  logic [31:0]      in_pc;
  logic [WIDTH-1:0] ins0;
  logic [WIDTH-1:0] ins1;
  logic             in_ready;
  logic [1:0]       out_count;
  logic [WIDTH-1:0] out0;
  logic [31:0]      out_pc0;
  logic [WIDTH-1:0] out1;
  logic [31:0]      out_pc1;
  logic [1:0]       deq;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_count, in_pc, ins0, ins1, deq,
    input  in_ready, out_count, out0, out_pc0, out1, out_pc1, occupancy
  );

  modport slave (
    input  flush, in_valid, in_count, in_pc, ins0, ins1, deq,
    output in_ready, out_count, out0, out_pc0, out1, out_pc1, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue between the dual-word instruction memory and decode.
// Accepts up to two words per cycle, presents up to two in-order words per cycle.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] head1;
  logic [PTR_W-1:0] tail1;
  logic             ready_c;
  logic [1:0]       avail_c;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  logic             wr0_en;
  logic             wr1_en;

  assign head1   = head_q + PTR_W'(1);
  assign tail1   = tail_q + PTR_W'(1);
  assign ready_c = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
  assign avail_c = (count_q >= CNT_W'(2)) ? 2'd2 : 2'(count_q);

  // Accepted enqueue and clamped dequeue counts for this cycle.
  always_comb begin
    n_enq = 2'd0;
    n_deq = bus.deq;
    if (bus.in_valid && ready_c) begin
      n_enq = (bus.in_count >= 2'd2) ? 2'd2 : bus.in_count;
    end
    if (bus.deq > avail_c) begin
      n_deq = avail_c;
    end
  end

  assign wr0_en = !bus.flush && (n_enq != 2'd0);
  assign wr1_en = !bus.flush && (n_enq == 2'd2);

  // Pointer and count update; flush overrides any concurrent enqueue/dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_deq);
      tail_d  = tail_q + PTR_W'(n_enq);
      count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage; the second word of a pair carries pc+4 with natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_en) begin
        mem_q[tail_q] <= '{pc: bus.in_pc, instr: bus.ins0};
      end
      if (wr1_en) begin
        mem_q[tail1] <= '{pc: bus.in_pc + 32'd4, instr: bus.ins1};
      end
    end
  end

  // Outputs depend on registered state only, zeroed where no entry is present.
  assign bus.in_ready  = ready_c;
  assign bus.out_count = avail_c;
  assign bus.occupancy = count_q;
  assign bus.out0      = (avail_c != 2'd0) ? mem_q[head_q].instr : '0;
  assign bus.out_pc0   = (avail_c != 2'd0) ? mem_q[head_q].pc    : '0;
  assign bus.out1      = (avail_c == 2'd2) ? mem_q[head1].instr  : '0;
  assign bus.out_pc1   = (avail_c == 2'd2) ? mem_q[head1].pc     : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue of expected entries is
// updated as stimulus is driven and compared with the head outputs every cycle.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  ent_t sb[$];

  fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the reference queue.
  task automatic check_state(input string ph);
    int sz;
    logic [31:0] e0, p0, e1, p1;
    sz = sb.size();
    e0 = '0; p0 = '0; e1 = '0; p1 = '0;
    if (sz >= 1) begin
      e0 = sb[0].ins;
      p0 = sb[0].pc;
    end
    if (sz >= 2) begin
      e1 = sb[1].ins;
      p1 = sb[1].pc;
    end
    chk({ph, ".occupancy"}, 64'(fq.occupancy), 64'(sz));
    chk({ph, ".in_ready"},  64'(fq.in_ready),  64'((DEPTH - sz) >= 2));
    chk({ph, ".out_count"}, 64'(fq.out_count), 64'((sz >= 2) ? 2 : sz));
    chk({ph, ".out0"},      64'(fq.out0),      64'(e0));
    chk({ph, ".out_pc0"},   64'(fq.out_pc0),   64'(p0));
    chk({ph, ".out1"},      64'(fq.out1),      64'(e1));
    chk({ph, ".out_pc1"},   64'(fq.out_pc1),   64'(p1));
  endtask

  task automatic idle_inputs();
    fq.flush    = 1'b0;
    fq.in_valid = 1'b0;
    fq.in_count = 2'd0;
    fq.in_pc    = '0;
    fq.ins0     = '0;
    fq.ins1     = '0;
    fq.deq      = 2'd0;
  endtask

  // One clock: drive, check current state, advance the reference model, clock.
  task automatic step(input string ph, input logic fl, input logic v, input logic [1:0] c,
                      input logic [31:0] pc, input logic [1:0] dq);
    logic [31:0] a, b;
    int sz, n, avail, d;
    a = $urandom();
    b = $urandom();
    fq.flush    = fl;
    fq.in_valid = v;
    fq.in_count = c;
    fq.in_pc    = pc;
    fq.ins0     = a;
    fq.ins1     = b;
    fq.deq      = dq;
    check_state(ph);
    sz    = sb.size();
    n     = (v && ((DEPTH - sz) >= 2)) ? ((c >= 2) ? 2 : int'(c)) : 0;
    avail = (sz >= 2) ? 2 : sz;
    d     = (int'(dq) > avail) ? avail : int'(dq);
    if (fl) begin
      sb.delete();
    end else begin
      repeat (d) void'(sb.pop_front());
      if (n >= 1) sb.push_back('{pc: pc, ins: a});
      if (n == 2) sb.push_back('{pc: pc + 32'd4, ins: b});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    #2;
    check_state("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single pair becomes visible one edge later.
    step("t1_enq", 1'b0, 1'b1, 2'd2, 32'h100, 2'd0);
    step("t1_see", 1'b0, 1'b0, 2'd0, 32'h0, 2'd0);

    // Fill to full with pairs; a further pair must be refused.
    step("t2_p2", 1'b0, 1'b1, 2'd2, 32'h108, 2'd0);
    step("t2_p3", 1'b0, 1'b1, 2'd2, 32'h110, 2'd0);
    step("t2_p4", 1'b0, 1'b1, 2'd2, 32'h118, 2'd0);
    step("t2_p5", 1'b0, 1'b1, 2'd2, 32'h120, 2'd0);
    step("t2_full", 1'b0, 1'b0, 2'd0, 32'h0, 2'd0);

    // Full: dequeue works while the offered pair is dropped; then enqueue at wrapped tail.
    step("t3_deqf", 1'b0, 1'b1, 2'd2, 32'h120, 2'd2);
    step("t3_both", 1'b0, 1'b1, 2'd2, 32'h120, 2'd2);
    step("t3_both2", 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFC, 2'd2);
    repeat (3) step("t3_drain", 1'b0, 1'b0, 2'd0, 32'h0, 2'd2);
    step("t3_empty", 1'b0, 1'b0, 2'd0, 32'h0, 2'd0);

    // Clamped dequeue from a single entry.
    step("t4_one", 1'b0, 1'b1, 2'd1, 32'h200, 2'd0);
    step("t4_clamp", 1'b0, 1'b0, 2'd0, 32'h0, 2'd2);
    step("t4_after", 1'b0, 1'b1, 2'd0, 32'h300, 2'd3);

    // Flush beats a simultaneous enqueue and dequeue.
    step("t5_a", 1'b0, 1'b1, 2'd2, 32'h400, 2'd0);
    step("t5_b", 1'b0, 1'b1, 2'd2, 32'h408, 2'd0);
    step("t5_c", 1'b0, 1'b1, 2'd1, 32'h410, 2'd0);
    step("t5_flush", 1'b1, 1'b1, 2'd2, 32'h414, 2'd1);
    step("t5_after", 1'b0, 1'b0, 2'd0, 32'h0, 2'd0);

    // Asynchronous reset mid-stream clears everything without a clock edge.
    step("t6_a", 1'b0, 1'b1, 2'd2, 32'h500, 2'd0);
    step("t6_b", 1'b0, 1'b1, 2'd2, 32'h508, 2'd0);
    step("t6_c", 1'b0, 1'b1, 2'd2, 32'h510, 2'd0);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check_state("t6_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("t6_enq", 1'b0, 1'b1, 2'd2, 32'h600, 2'd0);
    step("t6_see", 1'b0, 1'b0, 2'd0, 32'h0, 2'd1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom(), 2'($urandom_range(0, 3)));
    end
    repeat (5) step("fin_drain", 1'b0, 1'b0, 2'd0, 32'h0, 2'd2);
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
